// File: rtl/aes_sched_pkg.sv
// Shared types and sizes for the byte-serial AES core scheduler.
package aes_sched_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned KEY_BYTES   = 16;
  localparam int unsigned IdxW        = $clog2(BLOCK_BYTES);

  typedef logic req_id_t;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StStart,
    StKey,
    StData,
    StWait,
    StDrain
  } sched_state_e;

endpackage

// File: rtl/aes_byte_buf.sv
// 16x8 register file with one write port and one asynchronous read port.
module aes_byte_buf
  import aes_sched_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  logic [7:0]      wdata_i,
  input  logic [IdxW-1:0] raddr_i,
  output logic [7:0]      rdata_o
);

  logic [7:0] mem_q [BLOCK_BYTES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aes_core_sched.sv
// Two-requester scheduler feeding a byte-serial AES core: key, then plaintext, then ciphertext.
// Optional output watchdog enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_core_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       key_we_i,
  input  logic [7:0] key_byte_i,
  input  logic [1:0] req_valid_i,
  input  logic [7:0] req_data0_i,
  input  logic [7:0] req_data1_i,
  output logic [1:0] req_ready_o,
  output logic       core_en_o,
  output logic [7:0] core_data_o,
  input  logic [7:0] core_out_i,
  input  logic       core_out_ready_i,
  output logic       res_valid_o,
  output logic [7:0] res_data_o,
  output logic       res_id_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(BLOCK_BYTES - 1);

  sched_state_e    state_q, state_d;
  req_id_t         grant_q, grant_d;
  req_id_t         prio_q, prio_d;
  logic [IdxW-1:0] kptr_q, kptr_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic            res_valid_q, res_valid_d;
  logic [7:0]      res_data_q, res_data_d;
  req_id_t         res_id_q, res_id_d;
  logic            err_q, err_d;

  logic       out_phase, out_fire, tmo_hit;
  logic       key_we, pt_we;
  logic [7:0] key_rdata, pt_rdata;

  assign out_phase = (state_q == StWait) || (state_q == StDrain);
  assign out_fire  = out_phase && core_out_ready_i;
  assign key_we    = (state_q == StIdle) && key_we_i;
  assign pt_we     = (state_q == StFill) && req_valid_i[grant_q];

  aes_byte_buf u_key_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (key_we),
    .waddr_i (kptr_q),
    .wdata_i (key_byte_i),
    .raddr_i (cnt_q),
    .rdata_o (key_rdata)
  );

  aes_byte_buf u_pt_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (pt_we),
    .waddr_i (cnt_q),
    .wdata_i (grant_q ? req_data1_i : req_data0_i),
    .raddr_i (cnt_q),
    .rdata_o (pt_rdata)
  );

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counts consecutive output-phase cycles without a core byte.
  assign tmo_hit = out_phase && !core_out_ready_i && (int'(tmo_q) + 1 == int'(TIMEOUT));

  always_comb begin
    tmo_d = '0;
    if (out_phase && !core_out_ready_i && !tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      prio_q      <= '0;
      kptr_q      <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      prio_q      <= prio_d;
      kptr_q      <= kptr_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    prio_d      = prio_q;
    kptr_d      = kptr_q;
    cnt_d       = cnt_q;
    res_valid_d = out_fire;
    res_data_d  = out_fire ? core_out_i : '0;
    res_id_d    = out_fire ? grant_q : '0;
    err_d       = tmo_hit;
    unique case (state_q)
      StIdle: begin
        if (key_we_i) kptr_d = kptr_q + 1'b1;
        if (|req_valid_i) begin
          // prio_q names the requester that wins a tie; it flips away from each finished grant.
          grant_d = (&req_valid_i) ? prio_q : req_id_t'(req_valid_i[1]);
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        if (req_valid_i[grant_q]) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) state_d = StStart;
        end
      end
      StStart: state_d = StKey;
      StKey: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) state_d = StData;
      end
      StData: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) state_d = StWait;
      end
      StWait: begin
        if (core_out_ready_i) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (core_out_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d = StIdle;
            prio_d  = ~grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (tmo_hit) begin
      state_d = StIdle;
      prio_d  = ~grant_q;
      cnt_d   = '0;
    end
  end

  always_comb begin
    req_ready_o = '0;
    core_en_o   = 1'b0;
    core_data_o = '0;
    unique case (state_q)
      StFill:  req_ready_o[grant_q] = 1'b1;
      StStart: core_en_o = 1'b1;
      StKey:   core_data_o = key_rdata;
      StData:  core_data_o = pt_rdata;
      default: ;
    endcase
  end

  assign busy_o      = (state_q != StIdle);
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_id_o    = res_id_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_aes_core_sched.sv
// Scoreboard bench for aes_core_sched with a behavioural byte-serial core model.
module tb_aes_core_sched;

  typedef logic [15:0][7:0] blk_t;  // byte 0 lives in element 15
  typedef struct packed {logic id; logic [7:0] data;} res_t;
  typedef struct packed {logic id; blk_t pt;} blkexp_t;

  logic       clk_i, rst_i, key_we_i;
  logic [7:0] key_byte_i, req_data0_i, req_data1_i, core_data_o, core_out_i, res_data_o;
  logic [1:0] req_valid_i, req_ready_o;
  logic       core_en_o, core_out_ready_i, res_valid_o, res_id_o, busy_o, err_o;

  int      checks, errors, res_seen, err_seen;
  blk_t    key_m;
  res_t    res_q[$];
  blkexp_t blk_q[$];
  int      grant_log[$];

  int         cphase, ccnt, ocnt, owait, oslot, olimit, en_extra;
  bit         core_gaps, core_stuck;
  logic [7:0] cap [32];
  blk_t       cout;

  aes_core_sched #(.TIMEOUT(20)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .key_we_i         (key_we_i),
    .key_byte_i       (key_byte_i),
    .req_valid_i      (req_valid_i),
    .req_data0_i      (req_data0_i),
    .req_data1_i      (req_data1_i),
    .req_ready_o      (req_ready_o),
    .core_en_o        (core_en_o),
    .core_data_o      (core_data_o),
    .core_out_i       (core_out_i),
    .core_out_ready_i (core_out_ready_i),
    .res_valid_o      (res_valid_o),
    .res_data_o       (res_data_o),
    .res_id_o         (res_id_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Stand-in cipher: exact FIPS-197 vector, otherwise a keyed byte mix.
  function automatic blk_t cipher(input blk_t k, input blk_t p);
    blk_t c;
    if (k == 128'h000102030405060708090a0b0c0d0e0f && p == 128'h00112233445566778899aabbccddeeff)
      c = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    else
      for (int i = 0; i < 16; i++) c[15-i] = p[15-i] ^ k[i] ^ 8'(i * 17);
    return c;
  endfunction

  // Result monitor: pop the scoreboard on every ciphertext byte.
  always @(negedge clk_i) begin
    res_t e;
    if (res_valid_o) begin
      res_seen++;
      checks++;
      if (res_q.size() == 0) begin
        errors++;
        $display("FAIL res_unexpected: got id=%0d data=%02h, required no output",
                 res_id_o, res_data_o);
      end else begin
        e = res_q.pop_front();
        if ({res_id_o, res_data_o} !== {e.id, e.data}) begin
          errors++;
          $display("FAIL res_byte: got id=%0d data=%02h, required id=%0d data=%02h",
                   res_id_o, res_data_o, e.id, e.data);
        end
      end
    end
    if (err_o) err_seen++;
  end

  // Core model: capture 16 key + 16 data bytes after core_en, then return 16 bytes.
  always @(negedge clk_i) begin
    blk_t    ck, cp;
    blkexp_t b;
    if (rst_i) begin
      cphase = 0;
      core_out_ready_i = 1'b0;
      core_out_i = 8'h00;
    end else begin
      case (cphase)
        0: begin
          core_out_ready_i = 1'b0;
          core_out_i = 8'h00;
          if (core_en_o) begin cphase = 1; ccnt = 0; en_extra = 0; end
        end
        1: begin
          cap[ccnt] = core_data_o;
          if (core_en_o) en_extra++;
          ccnt++;
          if (ccnt == 32) begin
            for (int i = 0; i < 16; i++) begin ck[15-i] = cap[i]; cp[15-i] = cap[16+i]; end
            checks++;
            if (ck !== key_m) begin
              errors++;
              $display("FAIL core_key: got %032h, required %032h", ck, key_m);
            end
            checks++;
            if (en_extra !== 0) begin
              errors++;
              $display("FAIL core_en_len: got %0d extra pulses, required 0", en_extra);
            end
            checks++;
            if (blk_q.size() == 0) begin
              errors++;
              $display("FAIL core_data: got %032h, required no block", cp);
            end else begin
              b = blk_q.pop_front();
              if (cp !== b.pt) begin
                errors++;
                $display("FAIL core_data: got %032h, required %032h", cp, b.pt);
              end
            end
            cout = cipher(ck, cp);
            cphase = 2; ocnt = 0; owait = 3; oslot = 0;
          end
        end
        default: begin
          core_out_ready_i = 1'b0;
          core_out_i = 8'h00;
          if (!busy_o) cphase = 0;
          else if (core_stuck || ocnt >= olimit) ;
          else if (owait > 0) owait--;
          else begin
            oslot++;
            if (!(core_gaps && (oslot % 3 == 0))) begin
              core_out_ready_i = 1'b1;
              core_out_i = cout[15-ocnt];
              ocnt++;
            end
          end
        end
      endcase
    end
  end

  task automatic write_key(input blk_t k, input int n);
    for (int i = 0; i < n; i++) begin
      key_we_i = 1'b1;
      key_byte_i = k[15-i];
      @(negedge clk_i);
    end
    key_we_i = 1'b0;
  endtask

  task automatic drive_reqs(input logic [1:0] act, input blk_t p0, input blk_t p1,
                            input int gap_at, input int gap_len, input bit kb_en,
                            input logic [7:0] kb, output int en_early);
    blk_t pt [2];
    int   idx [2];
    bit   done [2];
    int   gapc, cyc;
    bit   gapping;
    blk_t c;
    pt[0] = p0; pt[1] = p1; idx[0] = 0; idx[1] = 0;
    done[0] = !act[0]; done[1] = !act[1];
    gapc = 0; cyc = 0; en_early = 0;
    if (kb_en) begin key_we_i = 1'b1; key_byte_i = kb; end
    while (!(done[0] && done[1]) && cyc < 3000) begin
      if (core_en_o) en_early++;
      gapping = !done[0] && idx[0] == gap_at && gapc < gap_len && req_ready_o[0];
      if (gapping) gapc++;
      req_valid_i = {!done[1], !done[0] && !gapping};
      req_data0_i = done[0] ? 8'h00 : pt[0][15-idx[0]];
      req_data1_i = done[1] ? 8'h00 : pt[1][15-idx[1]];
      for (int r = 0; r < 2; r++) begin
        if (req_valid_i[r] && req_ready_o[r]) begin
          idx[r]++;
          if (idx[r] == 16) begin
            done[r] = 1'b1;
            grant_log.push_back(r);
            blk_q.push_back('{id: 1'(r), pt: pt[r]});
            c = cipher(key_m, pt[r]);
            for (int i = 0; i < 16; i++) res_q.push_back('{id: 1'(r), data: c[15-i]});
          end
        end
      end
      @(negedge clk_i);
      key_we_i = 1'b0;
      cyc++;
    end
    req_valid_i = 2'b00;
    checks++;
    if (!(done[0] && done[1])) begin
      errors++;
      $display("FAIL fill_timeout: got bytes %0d/%0d, required 16/16", idx[0], idx[1]);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((busy_o || res_q.size() != 0) && n < 1000) begin @(negedge clk_i); n++; end
    checks++;
    if (busy_o || res_q.size() != 0) begin
      errors++;
      $display("FAIL %s_done: got busy=%0d pending=%0d, required busy=0 pending=0",
               tag, busy_o, res_q.size());
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({busy_o, err_o, res_valid_o, res_data_o, res_id_o, core_en_o, core_data_o, req_ready_o}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0d res_valid=%0d core_en=%0d ready=%b, required 0",
               busy_o, res_valid_o, core_en_o, req_ready_o);
    end
    rst_i = 1'b0;
    key_m = '0;
    @(negedge clk_i);
  endtask

  task automatic test_arbitration();
    int   en;
    logic [3:0] order;
    grant_log.delete();
    drive_reqs(2'b11, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
               128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000, -1, 0, 1'b0, 8'h00, en);
    wait_done("arb1");
    drive_reqs(2'b11, 128'h0102_0304_0506_0708_090a_0b0c_0d0e_0f10,
               128'hf0e0_d0c0_b0a0_9080_7060_5040_3020_1000, -1, 0, 1'b0, 8'h00, en);
    wait_done("arb2");
    order = 4'hf;
    if (grant_log.size() == 4)
      order = {grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]};
    checks++;
    if (order !== 4'b0101) begin
      errors++;
      $display("FAIL arb_order: got %b (%0d grants), required 0101", order, grant_log.size());
    end
  endtask

  task automatic test_vector();
    int en;
    key_m = 128'h000102030405060708090a0b0c0d0e0f;
    write_key(key_m, 16);
    drive_reqs(2'b01, 128'h00112233445566778899aabbccddeeff, '0, -1, 0, 1'b0, 8'h00, en);
    wait_done("vector");
  endtask

  task automatic test_fill_gap();
    int en;
    core_gaps = 1'b1;
    drive_reqs(2'b01, 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef, '0, 7, 3, 1'b0, 8'h00, en);
    checks++;
    if (en !== 0) begin
      errors++;
      $display("FAIL fill_start_early: got %0d core_en during fill, required 0", en);
    end
    wait_done("gap");
    core_gaps = 1'b0;
  endtask

  task automatic test_key_ignored();
    int en;
    drive_reqs(2'b01, 128'h5a5a_0000_1234_5678_9abc_def0_1357_9bdf, '0, -1, 0, 1'b0, 8'h00, en);
    repeat (20) @(negedge clk_i);
    key_we_i = 1'b1;
    key_byte_i = 8'hff;
    @(negedge clk_i);
    key_we_i = 1'b0;
    wait_done("keyign1");
    drive_reqs(2'b10, '0, 128'h2468_ace0_1357_9bdf_0f1e_2d3c_4b5a_6978, -1, 0, 1'b0, 8'h00, en);
    wait_done("keyign2");
  endtask

  task automatic test_key_with_req();
    int en;
    key_m = 128'hc0c1_c2c3_c4c5_c6c7_c8c9_cacb_cccd_cecf;
    write_key(key_m, 15);
    drive_reqs(2'b01, 128'h7777_0101_8888_0202_9999_0303_aaaa_0404, '0, -1, 0, 1'b1,
               key_m[0], en);
    wait_done("keyreq");
  endtask

  task automatic test_reset_mid_drain();
    int en, base, n;
    olimit = 5;
    base = res_seen;
    drive_reqs(2'b01, 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100, '0, -1, 0, 1'b0, 8'h00, en);
    n = 0;
    while (res_seen < base + 5 && n < 300) begin @(negedge clk_i); n++; end
    checks++;
    if (res_seen - base !== 5) begin
      errors++;
      $display("FAIL drain_partial: got %0d bytes, required 5", res_seen - base);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({busy_o, res_valid_o, res_data_o, res_id_o, core_en_o, core_data_o, req_ready_o} !== '0)
    begin
      errors++;
      $display("FAIL drain_reset: got busy=%0d res_valid=%0d res_data=%02h, required 0",
               busy_o, res_valid_o, res_data_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    res_q.delete();
    olimit = 16;
    key_m = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
    write_key(key_m, 16);
    drive_reqs(2'b01, 128'h3141_5926_5358_9793_2384_6264_3383_2795, '0, -1, 0, 1'b0, 8'h00, en);
    wait_done("fresh");
  endtask

`ifdef AES_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int en;
    core_stuck = 1'b1;
    drive_reqs(2'b01, 128'h0000_1111_2222_3333_4444_5555_6666_7777, '0, -1, 0, 1'b0, 8'h00, en);
    checks++;
    if (core_en_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_start: got core_en=%0d, required 1", core_en_o);
    end
    repeat (52) @(negedge clk_i);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: got err=%0d, required 0", err_o);
    end
    @(negedge clk_i);
    checks++;
    if ({err_o, busy_o} !== 2'b10) begin
      errors++;
      $display("FAIL tmo_pulse: got err=%0d busy=%0d, required err=1 busy=0", err_o, busy_o);
    end
    @(negedge clk_i);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL tmo_len: got err=%0d, required 0", err_o);
    end
    res_q.delete();
    core_stuck = 1'b0;
  endtask
`endif

  task automatic test_end();
    int exp_err;
`ifdef AES_SCHED_TIMEOUT_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    checks++;
    if (res_q.size() != 0 || blk_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got res=%0d blk=%0d, required 0/0",
               res_q.size(), blk_q.size());
    end
    checks++;
    if (err_seen !== exp_err) begin
      errors++;
      $display("FAIL err_count: got %0d pulses, required %0d", err_seen, exp_err);
    end
  endtask

  initial begin
    checks = 0; errors = 0; res_seen = 0; err_seen = 0;
    rst_i = 1'b1; key_we_i = 1'b0; key_byte_i = 8'h00;
    req_valid_i = 2'b00; req_data0_i = 8'h00; req_data1_i = 8'h00;
    cphase = 0; olimit = 16; core_gaps = 1'b0; core_stuck = 1'b0; key_m = '0;
    test_reset();
    test_arbitration();
    test_vector();
    test_fill_gap();
    test_key_ignored();
    test_key_with_req();
    test_reset_mid_drain();
`ifdef AES_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/aes_core_sched.md
AES_CORE_SCHED -- requirements
Module: aes_core_sched

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles without core_out_ready in WAIT/DRAIN before abort (AES_SCHED_TIMEOUT_EN only).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 key_we  in  1  key byte write strobe; honoured only in IDLE.
REQ-005 key_byte  in  8  key byte; first write = key byte 0 (MSB of 128-bit key).
REQ-006 req_valid  in  2  per-requester plaintext byte valid.
REQ-007 req_data0, req_data1  in  8 each  plaintext bytes, byte 0 first.
REQ-008 req_ready  out  2  per-requester byte accept.
REQ-009 core_en  out  1  one-cycle start pulse to the byte-serial AES core.
REQ-010 core_data  out  8  byte driven to the core input_data.
REQ-011 core_out  in  8  core output_data.
REQ-012 core_out_ready  in  1  core output byte valid.
REQ-013 res_valid  out  1  ciphertext byte valid.
REQ-014 res_data  out  8  ciphertext byte.
REQ-015 res_id  out  1  requester owning res_data.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 err  out  1  one-cycle abort pulse.

Function
REQ-018 FSM states: IDLE, FILL, START, KEY, DATA, WAIT, DRAIN.
REQ-019 IDLE: key_we writes key_byte to key[kptr], kptr wraps 15->0; any req_valid grants a requester and moves to FILL next cycle.
REQ-020 Arbitration: single request wins; both requesting -> requester not granted last; after reset requester 0 has priority.
REQ-021 Grant holds from FILL until DRAIN exits; non-granted req_ready stays 0.
REQ-022 FILL: req_ready[g]=1; byte stored on req_valid&req_ready; after 16th byte -> START; gaps in req_valid permitted.
REQ-023 START: core_en=1 for exactly one cycle, then KEY.
REQ-024 KEY: core_data=key[0..15] on 16 consecutive cycles, then DATA.
REQ-025 DATA: core_data=buf[0..15] on 16 consecutive cycles, then WAIT; no bubbles between KEY and DATA.
REQ-026 core_data=0 and core_en=0 outside START/KEY/DATA.
REQ-027 WAIT: first cycle with core_out_ready enters DRAIN and counts as output byte 0.
REQ-028 WAIT/DRAIN: each core_out_ready cycle registers core_out into res_data, res_valid=1, res_id=g one cycle later; core_out_ready low = no output, counter holds.
REQ-029 After 16th output byte -> IDLE; last-grant updated to g; byte counters 4-bit, wrap 15->0 on state exit.
REQ-030 key_we in IDLE concurrent with a request: key byte written and grant issued in the same cycle.
REQ-031 key_we outside IDLE ignored; key and kptr unchanged.

Reset
REQ-032 rst (any state, including mid-block) -> IDLE; key, buffer, counters, kptr, last-grant cleared; all outputs 0 the cycle after rst sampled high.

Configuration
REQ-033 AES_SCHED_TIMEOUT_EN defined: WAIT/DRAIN count consecutive cycles without core_out_ready; reaching TIMEOUT -> err=1 one cycle, IDLE, last-grant updated, remaining bytes dropped.
REQ-034 AES_SCHED_TIMEOUT_EN undefined: no counter, err tied 0, WAIT/DRAIN wait indefinitely.

Structure
REQ-035 Package aes_sched_pkg: state enum, BLOCK_BYTES=16, KEY_BYTES=16, requester-id type.
REQ-036 Sub-module aes_byte_buf: 16x8 register file, write/read index, used for key and plaintext storage.

Verification
REQ-037 Key 000102..0f, req0 sends 00112233..ff -> core_en once, 16 key bytes then 16 data bytes back-to-back; with reference core, res_data 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, res_id=0.
REQ-038 Both req_valid high in same IDLE cycle after reset -> req0 granted first, req1 next; third contest grants req0.
REQ-039 req0 drops req_valid 3 cycles mid-FILL -> no byte lost, START only after 16th byte accepted.
REQ-040 key_we pulsed during DATA with 0xff -> key unchanged; next block reuses original key.
REQ-041 rst asserted in DRAIN after 5 output bytes -> outputs 0, busy=0 next cycle; fresh block then completes correctly.
REQ-042 AES_SCHED_TIMEOUT_EN, TIMEOUT=20, core_out_ready stuck 0 -> err pulse 20 cycles after entering WAIT, return to IDLE.
